// File: rtl/lpc_mailbox.sv
// Byte-wide LPC I/O mailbox: host writes fill an RX FIFO, host reads drain a TX FIFO.
// Also provides a 4-byte register window (DATA/STATUS/IER/IRQ) and a level interrupt.
module lpc_mailbox #(
    parameter logic [15:0] BASE_ADDR   = 16'h0CA0,
    parameter int          DEPTH       = 16,
    parameter logic [3:0]  IRQ_DEFAULT = 4'd10
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] lpc_addr_i,
    input  logic [7:0]  lpc_wdata_i,
    input  logic        lpc_data_wr_i,
    output logic        lpc_wr_done_o,
    input  logic        lpc_data_req_i,
    output logic        lpc_data_rd_o,
    output logic [7:0]  lpc_rdata_o,
    output logic [3:0]  irq_num_o,
    output logic        interrupt_o,
    input  logic [7:0]  tx_data_i,
    input  logic        tx_valid_i,
    output logic        tx_ready_o,
    output logic [7:0]  rx_data_o,
    output logic        rx_valid_o,
    input  logic        rx_ready_i
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_WR_ACK, ST_RD_ACK} state_t;

    state_t        state_reg, state_next;
    logic          wr_done_reg, wr_done_next;
    logic          data_rd_reg, data_rd_next;
    logic [7:0]    rdata_reg, rdata_next;
    logic [1:0]    ier_reg;
    logic [3:0]    irq_reg;
    logic          ovf_reg;
    logic          int_reg;

    logic [7:0]    tx_mem [DEPTH];
    logic [7:0]    rx_mem [DEPTH];
    logic [PW-1:0] tx_wr_ptr_reg, tx_rd_ptr_reg;
    logic [PW-1:0] rx_wr_ptr_reg, rx_rd_ptr_reg;

    logic          tx_empty, tx_full, rx_empty, rx_full;
    logic          hit;
    logic [1:0]    offset;
    logic [7:0]    read_value;
    logic          host_wr, host_rd;
    logic          tx_push, tx_pop, rx_push, rx_pop;
    logic          ovf_set, ovf_clr, ier_we, irq_we;

    // The extra pointer MSB tells a full buffer from an empty one.
    assign tx_empty = (tx_wr_ptr_reg == tx_rd_ptr_reg);
    assign tx_full  = (tx_wr_ptr_reg[AW] != tx_rd_ptr_reg[AW]) &&
                      (tx_wr_ptr_reg[AW-1:0] == tx_rd_ptr_reg[AW-1:0]);
    assign rx_empty = (rx_wr_ptr_reg == rx_rd_ptr_reg);
    assign rx_full  = (rx_wr_ptr_reg[AW] != rx_rd_ptr_reg[AW]) &&
                      (rx_wr_ptr_reg[AW-1:0] == rx_rd_ptr_reg[AW-1:0]);

    assign hit    = (lpc_addr_i[15:2] == BASE_ADDR[15:2]);
    assign offset = lpc_addr_i[1:0];

    always_comb begin
        read_value = 8'hFF;
        if (hit) begin
            case (offset)
                2'd0:    read_value = tx_empty ? 8'hFF : tx_mem[tx_rd_ptr_reg[AW-1:0]];
                2'd1:    read_value = {5'b0, ovf_reg, rx_full, ~tx_empty};
                2'd2:    read_value = {6'b0, ier_reg};
                default: read_value = {4'b0, irq_reg};
            endcase
        end
    end

    // Handshake FSM: the write level wins over the read level in IDLE.
    always_comb begin
        state_next   = state_reg;
        wr_done_next = wr_done_reg;
        data_rd_next = data_rd_reg;
        rdata_next   = rdata_reg;
        host_wr      = 1'b0;
        host_rd      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (lpc_data_wr_i) begin
                    host_wr      = 1'b1;
                    wr_done_next = 1'b1;
                    state_next   = ST_WR_ACK;
                end else if (lpc_data_req_i) begin
                    host_rd      = 1'b1;
                    rdata_next   = read_value;
                    data_rd_next = 1'b1;
                    state_next   = ST_RD_ACK;
                end
            end
            ST_WR_ACK: begin
                if (!lpc_data_wr_i) begin
                    wr_done_next = 1'b0;
                    state_next   = ST_IDLE;
                end
            end
            ST_RD_ACK: begin
                if (!lpc_data_req_i) begin
                    data_rd_next = 1'b0;
                    state_next   = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign rx_push = host_wr && hit && (offset == 2'd0) && !rx_full;
    assign ovf_set = host_wr && hit && (offset == 2'd0) && rx_full;
    assign ier_we  = host_wr && hit && (offset == 2'd2);
    assign irq_we  = host_wr && hit && (offset == 2'd3);
    assign tx_pop  = host_rd && hit && (offset == 2'd0) && !tx_empty;
    assign ovf_clr = host_rd && hit && (offset == 2'd1);
    assign tx_push = tx_valid_i && !tx_full;
    assign rx_pop  = !rx_empty && rx_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg     <= ST_IDLE;
            wr_done_reg   <= 1'b0;
            data_rd_reg   <= 1'b0;
            rdata_reg     <= 8'h00;
            ier_reg       <= 2'b00;
            irq_reg       <= IRQ_DEFAULT;
            ovf_reg       <= 1'b0;
            int_reg       <= 1'b0;
            tx_wr_ptr_reg <= '0;
            tx_rd_ptr_reg <= '0;
            rx_wr_ptr_reg <= '0;
            rx_rd_ptr_reg <= '0;
        end else begin
            state_reg   <= state_next;
            wr_done_reg <= wr_done_next;
            data_rd_reg <= data_rd_next;
            rdata_reg   <= rdata_next;
            if (ier_we)  ier_reg <= lpc_wdata_i[1:0];
            if (irq_we)  irq_reg <= lpc_wdata_i[3:0];
            if (ovf_set) ovf_reg <= 1'b1;
            else if (ovf_clr) ovf_reg <= 1'b0;
            if (tx_push) tx_wr_ptr_reg <= tx_wr_ptr_reg + 1'b1;
            if (tx_pop)  tx_rd_ptr_reg <= tx_rd_ptr_reg + 1'b1;
            if (rx_push) rx_wr_ptr_reg <= rx_wr_ptr_reg + 1'b1;
            if (rx_pop)  rx_rd_ptr_reg <= rx_rd_ptr_reg + 1'b1;
            // Sampled from settled registers, so it trails the causing change by one clock.
            int_reg <= (ier_reg[0] & ~tx_empty) | (ier_reg[1] & rx_empty);
        end
    end

    always_ff @(posedge clk_i) begin
        if (tx_push) tx_mem[tx_wr_ptr_reg[AW-1:0]] <= tx_data_i;
        if (rx_push) rx_mem[rx_wr_ptr_reg[AW-1:0]] <= lpc_wdata_i;
    end

    assign lpc_wr_done_o = wr_done_reg;
    assign lpc_data_rd_o = data_rd_reg;
    assign lpc_rdata_o   = rdata_reg;
    assign irq_num_o     = irq_reg;
    assign interrupt_o   = int_reg;
    assign tx_ready_o    = ~tx_full;
    assign rx_valid_o    = ~rx_empty;
    assign rx_data_o     = rx_mem[rx_rd_ptr_reg[AW-1:0]];

endmodule

// File: tb/tb_lpc_mailbox.sv
// Directed and randomized checks of lpc_mailbox against a queue-based model
// of the register window, FIFOs and interrupt.
module tb_lpc_mailbox;
    localparam int          DEPTH = 16;
    localparam logic [15:0] BASE  = 16'h0CA0;
    localparam logic [3:0]  IRQD  = 4'd10;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] lpc_addr;
    logic [7:0]  lpc_wdata;
    logic        lpc_data_wr;
    logic        lpc_wr_done;
    logic        lpc_data_req;
    logic        lpc_data_rd;
    logic [7:0]  lpc_rdata;
    logic [3:0]  irq_num;
    logic        interrupt;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [7:0] m_tx [$];
    logic [7:0] m_rx [$];
    logic       m_ovf;
    logic [1:0] m_ier;
    logic [3:0] m_irq;

    always #5 clk = ~clk;

    lpc_mailbox #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .IRQ_DEFAULT(IRQD)) dut (
        .clk_i(clk), .rst_i(rst),
        .lpc_addr_i(lpc_addr), .lpc_wdata_i(lpc_wdata),
        .lpc_data_wr_i(lpc_data_wr), .lpc_wr_done_o(lpc_wr_done),
        .lpc_data_req_i(lpc_data_req), .lpc_data_rd_o(lpc_data_rd),
        .lpc_rdata_o(lpc_rdata), .irq_num_o(irq_num), .interrupt_o(interrupt),
        .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
        .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic m_hit(input logic [15:0] a);
        return a[15:2] == BASE[15:2];
    endfunction

    function automatic logic m_int();
        return (m_ier[0] && m_tx.size() > 0) || (m_ier[1] && m_rx.size() == 0);
    endfunction

    task automatic model_reset();
        m_tx.delete(); m_rx.delete();
        m_ovf = 1'b0; m_ier = 2'b00; m_irq = IRQD;
    endtask

    task automatic host_write(input logic [15:0] a, input logic [7:0] d);
        int hold;
        hold = $urandom_range(0, 2);
        @(negedge clk);
        chk("wr_done_idle", 32'(lpc_wr_done), 32'(1'b0));
        lpc_addr = a; lpc_wdata = d; lpc_data_wr = 1'b1;
        @(posedge clk); #1;
        chk("wr_done_rise", 32'(lpc_wr_done), 32'(1'b1));
        if (m_hit(a)) begin
            case (a[1:0])
                2'd0: if (m_rx.size() < DEPTH) m_rx.push_back(d); else m_ovf = 1'b1;
                2'd2: m_ier = d[1:0];
                2'd3: m_irq = d[3:0];
                default: ;
            endcase
        end
        repeat (hold) begin
            @(posedge clk); #1;
            chk("wr_done_hold", 32'(lpc_wr_done), 32'(1'b1));
        end
        @(negedge clk); lpc_data_wr = 1'b0;
        @(posedge clk); #1;
        chk("wr_done_fall", 32'(lpc_wr_done), 32'(1'b0));
        $display("[TB] write addr=%04h data=%02h", a, d);
    endtask

    function automatic logic [7:0] model_read(input logic [15:0] a);
        if (!m_hit(a)) return 8'hFF;
        case (a[1:0])
            2'd0: return (m_tx.size() == 0) ? 8'hFF : m_tx[0];
            2'd1: return {5'b0, m_ovf, m_rx.size() == DEPTH, m_tx.size() > 0};
            2'd2: return {6'b0, m_ier};
            default: return {4'b0, m_irq};
        endcase
    endfunction

    task automatic host_read(input logic [15:0] a, output logic [7:0] d);
        logic [7:0] exp;
        int hold;
        hold = $urandom_range(0, 2);
        exp = model_read(a);
        @(negedge clk);
        chk("data_rd_idle", 32'(lpc_data_rd), 32'(1'b0));
        lpc_addr = a; lpc_data_req = 1'b1;
        @(posedge clk); #1;
        chk("data_rd_rise", 32'(lpc_data_rd), 32'(1'b1));
        chk("rdata", 32'(lpc_rdata), 32'(exp));
        d = lpc_rdata;
        if (m_hit(a) && a[1:0] == 2'd0 && m_tx.size() > 0) void'(m_tx.pop_front());
        if (m_hit(a) && a[1:0] == 2'd1) m_ovf = 1'b0;
        repeat (hold) begin
            @(posedge clk); #1;
            chk("rdata_stable", 32'(lpc_rdata), 32'(exp));
        end
        @(negedge clk); lpc_data_req = 1'b0;
        @(posedge clk); #1;
        chk("data_rd_fall", 32'(lpc_data_rd), 32'(1'b0));
        $display("[TB] read  addr=%04h data=%02h exp=%02h", a, d, exp);
    endtask

    task automatic local_push(input logic [7:0] d);
        @(negedge clk);
        chk("tx_ready", 32'(tx_ready), 32'(m_tx.size() < DEPTH));
        tx_data = d; tx_valid = 1'b1;
        @(posedge clk); #1;
        if (m_tx.size() < DEPTH) m_tx.push_back(d);
        @(negedge clk); tx_valid = 1'b0;
        $display("[TB] push  data=%02h tx_count=%0d", d, m_tx.size());
    endtask

    task automatic local_pop();
        @(negedge clk);
        chk("rx_valid", 32'(rx_valid), 32'(m_rx.size() > 0));
        if (m_rx.size() > 0) chk("rx_data", 32'(rx_data), 32'(m_rx[0]));
        rx_ready = 1'b1;
        @(posedge clk); #1;
        if (m_rx.size() > 0) void'(m_rx.pop_front());
        @(negedge clk); rx_ready = 1'b0;
        $display("[TB] pop   rx_count=%0d", m_rx.size());
    endtask

    // One extra clock lets the registered interrupt catch up with the state.
    task automatic settle();
        @(posedge clk); #1;
        chk("interrupt", 32'(interrupt), 32'(m_int()));
        chk("irq_num", 32'(irq_num), 32'(m_irq));
        chk("tx_ready_lvl", 32'(tx_ready), 32'(m_tx.size() < DEPTH));
        chk("rx_valid_lvl", 32'(rx_valid), 32'(m_rx.size() > 0));
    endtask

    function automatic logic [15:0] pick_addr();
        if ($urandom_range(0, 9) < 8) return BASE + 16'($urandom_range(0, 3));
        return 16'($urandom);
    endfunction

    initial begin
        logic [7:0] d;
        int n;
        rst = 1'b1; lpc_addr = '0; lpc_wdata = '0; lpc_data_wr = 1'b0; lpc_data_req = 1'b0;
        tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_done", 32'(lpc_wr_done), 0);
        chk("rst_data_rd", 32'(lpc_data_rd), 0);
        chk("rst_interrupt", 32'(interrupt), 0);
        chk("rst_rdata", 32'(lpc_rdata), 0);
        chk("rst_irq_num", 32'(irq_num), 32'(IRQD));
        chk("rst_rx_valid", 32'(rx_valid), 0);
        chk("rst_tx_ready", 32'(tx_ready), 1);
        @(negedge clk); rst = 1'b0;

        // Host write then local pop
        host_write(BASE, 8'h5A);
        chk("rx_valid_after_wr", 32'(rx_valid), 1);
        chk("rx_data_after_wr", 32'(rx_data), 32'h5A);
        local_pop();
        settle();
        chk("rx_valid_after_pop", 32'(rx_valid), 0);

        // Local pushes, host reads incl. empty read
        local_push(8'h11); local_push(8'h22);
        host_read(BASE, d); chk("read1", 32'(d), 32'h11);
        host_read(BASE, d); chk("read2", 32'(d), 32'h22);
        host_read(BASE, d); chk("read_empty", 32'(d), 32'hFF);
        settle();

        // RX overflow and sticky OVF
        for (int i = 0; i <= DEPTH; i++) host_write(BASE, 8'($urandom));
        host_read(BASE + 16'd1, d); chk("status_ovf", 32'(d), 32'h06);
        host_read(BASE + 16'd1, d); chk("status_clr", 32'(d), 32'h02);
        while (m_rx.size() > 0) local_pop();
        settle();

        // Interrupt and IRQ register
        host_write(BASE + 16'd2, 8'h01);
        local_push(8'h33);
        @(posedge clk); #1;
        chk("int_data_avail", 32'(interrupt), 1);
        host_write(BASE + 16'd3, 8'hF3);
        chk("irq_num_f3", 32'(irq_num), 3);
        host_read(BASE + 16'd3, d); chk("irq_read", 32'(d), 32'h03);
        host_read(BASE + 16'd2, d); chk("ier_read", 32'(d), 32'h01);
        settle();

        // Randomized mix
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 3))
                0: host_write(pick_addr(), 8'($urandom));
                1: host_read(pick_addr(), d);
                2: local_push(8'($urandom));
                default: local_pop();
            endcase
            settle();
        end

        // Full TX FIFO: host read and refused local push in the same cycle
        while (m_tx.size() < DEPTH) local_push(8'($urandom));
        @(negedge clk);
        chk("tx_full_ready", 32'(tx_ready), 0);
        lpc_addr = BASE; lpc_data_req = 1'b1; tx_valid = 1'b1; tx_data = 8'hEE;
        @(posedge clk); #1;
        chk("simul_rdata", 32'(lpc_rdata), 32'(m_tx[0]));
        void'(m_tx.pop_front());
        @(negedge clk); lpc_data_req = 1'b0; tx_valid = 1'b0;
        @(posedge clk); #1;
        chk("simul_tx_ready", 32'(tx_ready), 1);
        $display("[TB] simultaneous read/push tx_count=%0d", m_tx.size());
        n = 0;
        while (m_tx.size() > 0) begin host_read(BASE, d); n++; end
        chk("simul_count", 32'(n), 32'(DEPTH - 1));
        host_read(BASE, d); chk("drained", 32'(d), 32'hFF);

        // Reset while in RD_ACK
        host_write(BASE + 16'd3, 8'h05);
        local_push(8'h44);
        host_write(BASE, 8'h77);
        @(negedge clk); lpc_addr = BASE; lpc_data_req = 1'b1;
        @(posedge clk); #1;
        chk("pre_rst_data_rd", 32'(lpc_data_rd), 1);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        model_reset();
        chk("mid_rst_data_rd", 32'(lpc_data_rd), 0);
        chk("mid_rst_wr_done", 32'(lpc_wr_done), 0);
        chk("mid_rst_rx_valid", 32'(rx_valid), 0);
        chk("mid_rst_tx_ready", 32'(tx_ready), 1);
        chk("mid_rst_irq_num", 32'(irq_num), 32'(IRQD));
        chk("mid_rst_rdata", 32'(lpc_rdata), 0);
        @(negedge clk); rst = 1'b0; lpc_data_req = 1'b0;
        host_read(16'h0080, d); chk("miss_read", 32'(d), 32'hFF);
        host_read(BASE, d); chk("post_rst_empty", 32'(d), 32'hFF);
        settle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end
endmodule
